// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the core sequencer and its watchdog.
package core_ctrl_pkg;

  // Stage indices into the enable/done vectors.
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  localparam int STG_COUNT  = 5;

  // Width of the per-stage wait counter (TIMEOUT range is 1..255).
  localparam int WDOG_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } seq_state_t;

  // True for states that run the issue/wait handshake with a stage.
  function automatic logic is_stage_state(seq_state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
           (s == S_MEM) || (s == S_WB);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake and status bundle between the sequencer and the stage modules.
interface core_sequencer_if;
  logic        start;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        fetch_done, decode_done, exec_done, mem_done, wb_done;
  logic        is_mem, is_ecall, is_ebreak, is_mret;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  // Sequencer side.
  modport master (
    input  start,
    output fetch_en, decode_en, exec_en, mem_en, wb_en,
    input  fetch_done, decode_done, exec_done, mem_done, wb_done,
    input  is_mem, is_ecall, is_ebreak, is_mret,
    input  branch_taken, branch_target,
    output pc, epc, halted, fault, instret
  );

  // Stage / environment side.
  modport slave (
    output start,
    input  fetch_en, decode_en, exec_en, mem_en, wb_en,
    output fetch_done, decode_done, exec_done, mem_done, wb_done,
    output is_mem, is_ecall, is_ebreak, is_mret,
    output branch_taken, branch_target,
    input  pc, epc, halted, fault, instret
  );
endinterface

// File: rtl/core_sequencer_watchdog.sv
// Wait-cycle counter: cleared on a stage's issue cycle, counts its wait
// cycles and flags the wait cycle that exhausts the TIMEOUT budget.
module stage_watchdog
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count_q;
  logic [WDOG_W-1:0] count_d;

  // Clear wins over increment; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current wait cycle is the TIMEOUT-th one without a done.
  assign expire_o = en_i && (count_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks fetch/decode/exec/mem/wb with an
// issue/wait handshake per stage, owns PC, trap/halt flow and instret.
module core_sequencer
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] TRAP_VEC = 32'd47,
  parameter int          TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rstn,
  core_sequencer_if.master bus
);

  seq_state_t state_q, state_d;
  logic        issue_q, issue_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] instret_q, instret_d;
  logic        is_mem_q, is_mem_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [STG_COUNT-1:0] en;
  logic                 stage_done;
  logic                 wait_phase;
  logic                 wdog_expire;

  // Done is only honoured after the issue cycle of a stage state.
  assign wait_phase = is_stage_state(state_q) && !issue_q;

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (issue_q),
    .en_i     (wait_phase),
    .expire_o (wdog_expire)
  );

  // Next-state, architectural updates and stage enables.
  always_comb begin
    state_d    = state_q;
    issue_d    = 1'b0;
    pc_d       = pc_q;
    epc_d      = epc_q;
    instret_d  = instret_q;
    is_mem_d   = is_mem_q;
    taken_d    = taken_q;
    target_d   = target_q;
    en         = '0;
    stage_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          issue_d = 1'b1;
        end
      end
      S_FETCH: begin
        en[STG_FETCH] = issue_q;
        stage_done    = bus.fetch_done;
        if (wait_phase && bus.fetch_done) begin
          state_d = S_DECODE;
          issue_d = 1'b1;
        end
      end
      S_DECODE: begin
        en[STG_DECODE] = issue_q;
        stage_done     = bus.decode_done;
        if (wait_phase && bus.decode_done) begin
          is_mem_d = bus.is_mem;
          if (bus.is_ebreak) begin
            state_d   = S_HALT;
            instret_d = instret_q + 32'd1;
          end else if (bus.is_ecall) begin
            epc_d     = pc_q;
            pc_d      = TRAP_VEC;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
            issue_d   = 1'b1;
          end else if (bus.is_mret) begin
            pc_d      = epc_q + 32'd1;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
            issue_d   = 1'b1;
          end else begin
            state_d = S_EXEC;
            issue_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        en[STG_EXEC] = issue_q;
        stage_done   = bus.exec_done;
        if (wait_phase && bus.exec_done) begin
          taken_d  = bus.branch_taken;
          target_d = bus.branch_target;
          state_d  = is_mem_q ? S_MEM : S_WB;
          issue_d  = 1'b1;
        end
      end
      S_MEM: begin
        en[STG_MEM] = issue_q;
        stage_done  = bus.mem_done;
        if (wait_phase && bus.mem_done) begin
          state_d = S_WB;
          issue_d = 1'b1;
        end
      end
      S_WB: begin
        en[STG_WB] = issue_q;
        stage_done = bus.wb_done;
        if (wait_phase && bus.wb_done) begin
          pc_d      = taken_q ? target_q : pc_q + 32'd1;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
          issue_d   = 1'b1;
        end
      end
      S_HALT: begin
        if (bus.start) begin
          pc_d    = pc_q + 32'd1;
          state_d = S_FETCH;
          issue_d = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A stage that never answers within the budget parks the core in FAULT.
    if (wait_phase && !stage_done && wdog_expire) begin
      state_d = S_FAULT;
      issue_d = 1'b0;
    end
    halted_d = (state_d == S_HALT);
    fault_d  = (state_d == S_FAULT);
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      issue_q   <= 1'b0;
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      instret_q <= '0;
      is_mem_q  <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      instret_q <= instret_d;
      is_mem_q  <= is_mem_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.fetch_en  = en[STG_FETCH];
  assign bus.decode_en = en[STG_DECODE];
  assign bus.exec_en   = en[STG_EXEC];
  assign bus.mem_en    = en[STG_MEM];
  assign bus.wb_en     = en[STG_WB];
  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.instret   = instret_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stages answer one cycle after their
// enable; each instruction pushes its expected next-fetch state and pops it
// when the DUT issues the next fetch (or halts).
module tb_core_sequencer;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if bus ();

  core_sequencer #(
    .RESET_PC (32'd0),
    .TRAP_VEC (32'd47),
    .TIMEOUT  (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    string           name;
    logic [31:0]     pc;
    logic [31:0]     instret;
    logic [31:0]     epc;
    int              lat;
    logic [4:0][7:0] offs;
    logic            halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] en_prev   = '0;
  logic [4:0] done_mask = '1;

  localparam logic [39:0] OFF_ALU = {8'd6, 8'hFF, 8'd4, 8'd2, 8'd0};
  localparam logic [39:0] OFF_MEM = {8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
  localparam logic [39:0] OFF_SYS = {8'hFF, 8'hFF, 8'hFF, 8'd2, 8'd0};

  function automatic logic [4:0] cur_en();
    return {bus.wb_en, bus.mem_en, bus.exec_en, bus.decode_en, bus.fetch_en};
  endfunction

  task automatic clear_inputs();
    bus.start = 1'b0;
    {bus.wb_done, bus.mem_done, bus.exec_done, bus.decode_done, bus.fetch_done} = '0;
    bus.is_mem = 1'b0; bus.is_ecall = 1'b0; bus.is_ebreak = 1'b0; bus.is_mret = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    en_prev = '0;
  endtask

  // Advance to the next falling edge, check enable exclusivity and answer
  // the stage enabled in the previous cycle.
  task automatic step();
    logic [4:0] e;
    @(negedge clk);
    e = cur_en();
    n_cmp++;
    if ($countones(e) > 1) begin
      n_bad++;
      $display("FAIL onehot: enables=%b required at most one high", e);
    end
    {bus.wb_done, bus.mem_done, bus.exec_done, bus.decode_done, bus.fetch_done} = en_prev & done_mask;
    en_prev = e;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Called at the fetch-issue cycle of an instruction.
  task automatic run_instr(input string name, input logic mem, input logic ecall,
                           input logic ebreak, input logic mret, input logic taken,
                           input logic [31:0] target, input logic hold_start,
                           input logic [31:0] x_pc, input logic [31:0] x_ir,
                           input logic [31:0] x_epc, input int x_lat,
                           input logic [39:0] x_offs, input logic x_halt);
    exp_t e;
    logic [4:0][7:0] offs;
    logic [4:0] en;
    int t;
    e.name = name; e.pc = x_pc; e.instret = x_ir; e.epc = x_epc;
    e.lat = x_lat; e.offs = x_offs; e.halt = x_halt;
    exp_q.push_back(e);
    bus.is_mem = mem; bus.is_ecall = ecall; bus.is_ebreak = ebreak; bus.is_mret = mret;
    bus.branch_taken = taken; bus.branch_target = target; bus.start = hold_start;
    offs = {5{8'hFF}};
    offs[0] = 8'd0;
    t = 0;
    while (t < 40) begin
      step();
      t++;
      en = en_prev;
      if (en[0]) break;
      for (int i = 1; i < 5; i++)
        if (en[i] && offs[i] == 8'hFF) offs[i] = 8'(t);
      if (bus.halted) break;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (t >= 40) begin
      n_bad++;
      $display("FAIL %s timeout: no fetch or halt within %0d cycles", e.name, t);
    end
    n_cmp++;
    if (t !== e.lat) begin
      n_bad++; $display("FAIL %s latency: got %0d required %0d", e.name, t, e.lat);
    end
    n_cmp++;
    if (bus.pc !== e.pc) begin
      n_bad++; $display("FAIL %s pc: got %0d required %0d", e.name, bus.pc, e.pc);
    end
    n_cmp++;
    if (bus.instret !== e.instret) begin
      n_bad++; $display("FAIL %s instret: got %0d required %0d", e.name, bus.instret, e.instret);
    end
    n_cmp++;
    if (bus.epc !== e.epc) begin
      n_bad++; $display("FAIL %s epc: got %0d required %0d", e.name, bus.epc, e.epc);
    end
    n_cmp++;
    if (bus.halted !== e.halt) begin
      n_bad++; $display("FAIL %s halted: got %b required %b", e.name, bus.halted, e.halt);
    end
    n_cmp++;
    if (offs !== e.offs) begin
      n_bad++; $display("FAIL %s enable offsets: got %h required %h", e.name, offs, e.offs);
    end
    $display("instr %-10s pc=%0d instret=%0d epc=%0d lat=%0d halted=%b",
             e.name, bus.pc, bus.instret, bus.epc, t, bus.halted);
  endtask

  task automatic check_fetch_issue(input string name, input logic [31:0] x_pc);
    n_cmp++;
    if (bus.fetch_en !== 1'b1) begin
      n_bad++; $display("FAIL %s fetch_en: got %b required 1", name, bus.fetch_en);
    end
    n_cmp++;
    if (bus.pc !== x_pc) begin
      n_bad++; $display("FAIL %s pc: got %0d required %0d", name, bus.pc, x_pc);
    end
    $display("start %-10s fetch_en=%b pc=%0d", name, bus.fetch_en, bus.pc);
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.pc, bus.epc, bus.instret} !== 96'd0) begin
      n_bad++; $display("FAIL reset regs: got pc=%0d epc=%0d instret=%0d required 0/0/0", bus.pc, bus.epc, bus.instret);
    end
    n_cmp++;
    if ({bus.halted, bus.fault, cur_en()} !== 7'd0) begin
      n_bad++; $display("FAIL reset flags: got halted=%b fault=%b en=%b required 0", bus.halted, bus.fault, cur_en());
    end
    rstn = 1'b1;
    step();
    step();
    n_cmp++;
    if (cur_en() !== 5'd0) begin
      n_bad++; $display("FAIL idle enables: got %b required 00000", cur_en());
    end
    $display("reset pc=%0d instret=%0d fault=%b", bus.pc, bus.instret, bus.fault);
  endtask

  task automatic test_alu_mem_branch();
    pulse_start();
    check_fetch_issue("first", 32'd0);
    run_instr("alu", 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'd1, 32'd1, 32'd0, 8, OFF_ALU, 1'b0);
    run_instr("load", 1, 0, 0, 0, 0, 32'd0, 1'b0, 32'd2, 32'd2, 32'd0, 10, OFF_MEM, 1'b0);
    run_instr("branch", 0, 0, 0, 0, 1, 32'd5, 1'b0, 32'd5, 32'd3, 32'd0, 8, OFF_ALU, 1'b0);
    for (int i = 0; i < 3; i++)
      run_instr("alu_seq", 0, 0, 0, 0, 0, (i == 1) ? 32'hDEAD : 32'd0, 1'b0,
                32'd6 + 32'(i), 32'd4 + 32'(i), 32'd0, 8, OFF_ALU, 1'b0);
  endtask

  task automatic test_traps();
    run_instr("ecall", 0, 1, 0, 0, 0, 32'd0, 1'b0, 32'd47, 32'd7, 32'd8, 4, OFF_SYS, 1'b0);
    run_instr("mret", 0, 0, 0, 1, 0, 32'd0, 1'b0, 32'd9, 32'd8, 32'd8, 4, OFF_SYS, 1'b0);
    run_instr("br_to_4", 0, 0, 0, 0, 1, 32'd4, 1'b0, 32'd4, 32'd9, 32'd8, 8, OFF_ALU, 1'b0);
  endtask

  task automatic test_halt();
    // ebreak outranks a simultaneous ecall.
    run_instr("ebreak", 0, 1, 1, 0, 0, 32'd0, 1'b0, 32'd4, 32'd10, 32'd8, 4, OFF_SYS, 1'b1);
    bus.is_ecall = 1'b0; bus.is_ebreak = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (cur_en() !== 5'd0 || bus.halted !== 1'b1 || bus.pc !== 32'd4) begin
        n_bad++; $display("FAIL halt hold: got en=%b halted=%b pc=%0d required 00000/1/4", cur_en(), bus.halted, bus.pc);
      end
    end
    pulse_start();
    check_fetch_issue("resume", 32'd5);
    n_cmp++;
    if (bus.halted !== 1'b0) begin
      n_bad++; $display("FAIL resume halted: got %b required 0", bus.halted);
    end
    run_instr("ecall_mret", 0, 1, 0, 1, 0, 32'd0, 1'b0, 32'd47, 32'd11, 32'd5, 4, OFF_SYS, 1'b0);
  endtask

  task automatic test_watchdog();
    int t;
    clear_inputs();
    en_prev = bus.fetch_en ? 5'b00001 : 5'b00000;
    done_mask = 5'b11011;
    t = 0;
    while (t < 20 && !bus.exec_en) begin
      step();
      t++;
    end
    n_cmp++;
    if (bus.exec_en !== 1'b1) begin
      n_bad++; $display("FAIL wdog reach exec: got exec_en=%b required 1", bus.exec_en);
    end
    repeat (4) step();
    n_cmp++;
    if (bus.fault !== 1'b0) begin
      n_bad++; $display("FAIL wdog early: got fault=%b required 0 in 4th wait cycle", bus.fault);
    end
    step();
    n_cmp++;
    if (bus.fault !== 1'b1 || cur_en() !== 5'd0) begin
      n_bad++; $display("FAIL wdog fault: got fault=%b en=%b required 1/00000", bus.fault, cur_en());
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.fault !== 1'b1 || cur_en() !== 5'd0 || bus.pc !== 32'd47) begin
        n_bad++; $display("FAIL fault sticky: got fault=%b en=%b pc=%0d required 1/00000/47", bus.fault, cur_en(), bus.pc);
      end
    end
    $display("watchdog fault=%b pc=%0d", bus.fault, bus.pc);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.fault !== 1'b0 || bus.pc !== 32'd0 || bus.instret !== 32'd0 || bus.epc !== 32'd0) begin
      n_bad++; $display("FAIL fault clear: got fault=%b pc=%0d instret=%0d epc=%0d required 0/0/0/0", bus.fault, bus.pc, bus.instret, bus.epc);
    end
    done_mask = '1;
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    $display("reset after fault fault=%b pc=%0d", bus.fault, bus.pc);
  endtask

  task automatic test_async_reset();
    int t;
    pulse_start();
    check_fetch_issue("after_flt", 32'd0);
    run_instr("alu2", 0, 0, 0, 0, 0, 32'd0, 1'b0, 32'd1, 32'd1, 32'd0, 8, OFF_ALU, 1'b0);
    bus.is_mem = 1'b1;
    t = 0;
    while (t < 20 && !bus.mem_en) begin
      step();
      t++;
    end
    n_cmp++;
    if (bus.mem_en !== 1'b1) begin
      n_bad++; $display("FAIL areset reach mem: got mem_en=%b required 1", bus.mem_en);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0 || cur_en() !== 5'd0) begin
      n_bad++; $display("FAIL areset enables: got en=%b required 00000", cur_en());
    end
    n_cmp++;
    if (bus.pc !== 32'd0 || bus.instret !== 32'd0) begin
      n_bad++; $display("FAIL areset regs: got pc=%0d instret=%0d required 0/0", bus.pc, bus.instret);
    end
    $display("async reset mem_en=%b pc=%0d instret=%0d", bus.mem_en, bus.pc, bus.instret);
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_mem_branch();
    test_traps();
    test_halt();
    test_watchdog();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
